instruction_ram_responder: RTL
==============================

# instruction_ram_responder

Responder end of the SRAM-like instruction/data memory interface: accepts address-phase requests from a fetch or memory stage, performs them on a single-port synchronous RAM and returns in-order data-phase responses after a fixed, parameterised latency. Used as the memory model behind the CPU core in simulation and as the on-chip boot RAM controller. Bounds in-flight transactions and supports externally forced address-phase stalls, so initiator wait, ignore and flush paths can be exercised deterministically.

## Interface
- `ADDRESS_WIDTH`, 14: RAM word-index width. The RAM holds 2^ADDRESS_WIDTH 32-bit words.
- `RESPONSE_DELAY`, 1: extra response pipeline stages, ≥1.
- `MAX_OUTSTANDING`, 2: maximum number of accepted but unanswered transactions, 1..RESPONSE_DELAY+1.
- `clock`  in  1: single clock, posedge.
- `reset`  in  1: asynchronous, active-low.
- `request`  in  1: address-phase request valid.
- `write`  in  1: 1 = write, 0 = read.
- `size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = treated as word. Informational only; `write_strobe` governs writes.
- `address`  in  32: byte address. Bits [ADDRESS_WIDTH+1:2] index the RAM; other bits are ignored.
- `write_data`  in  32: write data.
- `write_strobe`  in  4: byte enables for writes.
- `stall`  in  1: forces `address_ready` low.
- `address_ready`  out  1: address phase accepted this cycle.
- `data_ready`  out  1: one-cycle response pulse.
- `read_data`  out  32: response data.
- `ram_enable`  out  1: RAM access strobe.
- `ram_write_enable`  out  4: RAM byte write enables.
- `ram_address`  out  ADDRESS_WIDTH: RAM word index.
- `ram_write_data`  out  32: RAM write data.
- `ram_read_data`  in  32: RAM read data. Valid in the cycle after `ram_enable`.

## Operation
- Acceptance:
  - `address_ready = request && !stall && outstanding < MAX_OUTSTANDING`. This is combinational and may depend on same-cycle `request`.
  - A transaction is accepted in any cycle with `request && address_ready`. Back-to-back acceptance every cycle is allowed up to the limit.
- RAM access happens in the acceptance cycle, combinationally:
  - `ram_enable = request && address_ready`.
  - `ram_address = address[ADDRESS_WIDTH+1:2]`.
  - `ram_write_data = write_data`.
  - `ram_write_enable = {4{write && ram_enable}} & write_strobe`.
  - A write with a zero strobe still counts as a transaction and still gets a response.
- Response pipeline:
  - Stage 0 holds a `{valid, is_write}` token, loaded at the acceptance edge.
  - At the next edge the token moves to stage 1 together with `ram_read_data`. Data is forced to 0 for writes.
  - Stages 1..RESPONSE_DELAY shift every edge, unconditionally.
  - `data_ready` = valid bit of stage RESPONSE_DELAY. `read_data` = data of that stage.
- `read_data` holds its last emitted value while `data_ready` is low.
- Responses are strictly in acceptance order, one `data_ready` pulse per accepted transaction.
- The initiator must accept every response. There is no data-phase back-pressure.
- `outstanding` counter (width clog2(MAX_OUTSTANDING+1)):
  - +1 on accept, −1 on `data_ready`, unchanged when both happen in the same cycle.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- The response path ignores `request`, `stall` and `address`. In-flight transactions complete even if the initiator drops `request` or flushes. Discarding stale data is the initiator's job.
- `stall` only gates new acceptances and never cancels in-flight transactions.

## Timing
- Latency: a transaction accepted in cycle T has `data_ready` high in cycle T+RESPONSE_DELAY+1, exactly one cycle.
- Minimum latency is 2 cycles (RESPONSE_DELAY = 1).
- Throughput: one transaction per cycle when MAX_OUTSTANDING = RESPONSE_DELAY+1.
- With fewer outstanding slots, the full case re-opens `address_ready` in the same cycle as `data_ready`, through the decrement-visible compare `outstanding − data_ready < MAX_OUTSTANDING`.
- Reset (`reset` low, asynchronous) clears immediately:
  - all pipeline valid bits, `outstanding`, and `read_data` to 0;
  - `data_ready` to 0;
  - `address_ready` and `ram_enable` go to 0 because acceptance is gated by reset.
- Transactions in flight at reset are discarded with no response.
- Acceptance resumes in the first cycle after `reset` rises.

## Test plan
- Single read: RAM word 0x10 = 0x24080001; `request=1, write=0, address=0xbfc00040` (index 0x10) accepted in cycle 5 -> `data_ready=1, read_data=0x24080001` in cycle 7 only.
- Back-to-back: MAX_OUTSTANDING=2, RESPONSE_DELAY=1, reads of words 0,1,2,3 held continuously -> `address_ready` high every cycle, four in-order `data_ready` pulses in consecutive cycles.
- Limit: MAX_OUTSTANDING=1, RESPONSE_DELAY=2, continuous `request` -> one accept every 3 cycles, `outstanding` never >1.
- Byte write: write 0xAABBCCDD, strobe 4'b0100 to word 4 holding 0x11223344 -> `ram_write_enable=4'b0100` and a `data_ready` pulse with `read_data=0`; a subsequent read returns 0x11BB3344.
- Stall and flush: `stall` high 3 cycles with `request` high -> no accept; a request accepted then dropped next cycle -> response still delivered on schedule.
- Reset mid-flight: `reset` low one cycle after an accept -> no `data_ready`, `outstanding=0`, next request accepted in the first cycle after `reset` rises.

Source files
------------

// File: rtl/instruction_ram_responder.sv
// Responder for the SRAM-like instruction/data interface: issues accepted requests to a
// single-port synchronous RAM and returns in-order responses after a fixed latency.
module instruction_ram_responder #(
    parameter int ADDRESS_WIDTH   = 14,
    parameter int RESPONSE_DELAY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     request_i,
    input  logic                     write_i,
    input  logic [1:0]               size_i,
    input  logic [31:0]              address_i,
    input  logic [31:0]              write_data_i,
    input  logic [3:0]               write_strobe_i,
    input  logic                     stall_i,
    output logic                     address_ready_o,
    output logic                     data_ready_o,
    output logic [31:0]              read_data_o,
    output logic                     ram_enable_o,
    output logic [3:0]               ram_write_enable_o,
    output logic [ADDRESS_WIDTH-1:0] ram_address_o,
    output logic [31:0]              ram_write_data_o,
    input  logic [31:0]              ram_read_data_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic          s0_valid_q;
    logic          s0_write_q;
    logic          accept;
    logic          resp_valid;

    // Width and byte-offset information is not needed: the strobe alone shapes writes.
    logic unused_bits;
    assign unused_bits = ^{size_i, address_i[31:ADDRESS_WIDTH+2], address_i[1:0]};

    // A response leaving this cycle frees its slot for a same-cycle acceptance.
    assign address_ready_o = reset_ni && request_i && !stall_i &&
                             ((outstanding_q - CW'(resp_valid)) < CW'(MAX_OUTSTANDING));
    assign accept          = request_i && address_ready_o;

    assign ram_enable_o       = accept;
    assign ram_address_o      = address_i[ADDRESS_WIDTH+1:2];
    assign ram_write_data_o   = write_data_i;
    assign ram_write_enable_o = {4{write_i && accept}} & write_strobe_i;

    assign outstanding_d = outstanding_q + CW'(accept) - CW'(resp_valid);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            outstanding_q <= '0;
            s0_valid_q    <= 1'b0;
            s0_write_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            s0_valid_q    <= accept;
            s0_write_q    <= write_i;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= RESPONSE_DELAY; gi++) begin : g_stage
            logic        valid_q;
            logic [31:0] data_q;
            logic        valid_d;
            logic [31:0] data_d;

            if (gi == 1) begin : g_first
                assign valid_d = s0_valid_q;
                assign data_d  = s0_write_q ? 32'h0 : ram_read_data_i;
            end else begin : g_next
                assign valid_d = g_stage[gi-1].valid_q;
                assign data_d  = g_stage[gi-1].data_q;
            end

            // The last stage doubles as the output register, so it only loads real responses.
            always_ff @(posedge clock_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    if ((gi < RESPONSE_DELAY) || valid_d) begin
                        data_q <= data_d;
                    end
                end
            end
        end
    endgenerate

    assign resp_valid   = g_stage[RESPONSE_DELAY].valid_q;
    assign data_ready_o = resp_valid;
    assign read_data_o  = g_stage[RESPONSE_DELAY].data_q;

endmodule
